uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the RS-232 serial link: recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous `rs232_rx` line and presents each byte on a parallel bus with a one-cycle valid strobe. It is the receiving end of the serial link driven by `uart_tx` and uses the same baud-divider convention. It sits between the board pin and the byte-consuming logic.

## Interface
- `BAUD_DIV`, default 5208: clock cycles per bit (50 MHz / 9600 baud). Legal range ≥ 4. Counter width is `$clog2(BAUD_DIV)`.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RSTn`  in  1  asynchronous, active-low reset.
- `rs232_rx`  in  1  serial line, idle high, asynchronous to `CLK`.
- `rx_data`  out  8  last correctly framed byte. Held until the next good frame.
- `rx_done`  out  1  one-cycle pulse; `rx_data` is valid in the same cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `rx_busy`  out  1  high from start-edge detection until the stop-bit sample.

## Operation
- Synchronizer: 2 flops on `rs232_rx`, reset to 1, plus a third "previous" flop for edge detection, also reset to 1. All decisions use the synchronized value `rx_s`.
- The state machine has 4 states: IDLE, START, DATA, STOP. Counter `cnt` and bit index `bit_idx` (0..7). `HALF = BAUD_DIV/2`, using integer division.
- IDLE: a falling edge (prev=1, `rx_s`=0) moves the state to START, clears `cnt` to 0, and sets `rx_busy`=1. A line held low never re-triggers the machine; a new 1→0 transition is required.
- START: `cnt` increments each cycle. At `cnt == HALF-1`, `rx_s` is sampled:
  - If the sample is 1, it is a false start (glitch). The state returns to IDLE and `rx_busy` is cleared.
  - If the sample is 0, the state moves to DATA with `cnt`←0 and `bit_idx`←0.
- DATA: at `cnt == BAUD_DIV-1`, `rx_s` is sampled into shift register bit `bit_idx` (LSB first), and `cnt`←0. After bit 7 is sampled, the state moves to STOP.
- STOP: at `cnt == BAUD_DIV-1`, `rx_s` is sampled, then the state returns to IDLE and `rx_busy` is cleared.
  - If the sample is 1: `rx_data`←shift register and `rx_done` pulses.
  - If the sample is 0: `frame_err` pulses and `rx_data` is unchanged.
- The return to IDLE happens at mid-stop-bit. This leaves half a bit of margin, so a start bit immediately following the stop bit is caught.
- `rx_done` and `frame_err` are never high together. Each is high for exactly 1 cycle per frame.
- Edges on the line during START, DATA or STOP are ignored except at the sample points.

## Timing
- Reset values:
  - `rx_data`=8'h00, `rx_done`=0, `frame_err`=0, `rx_busy`=0.
  - State IDLE; `cnt`, `bit_idx` and the shift register are 0; synchronizer flops are 1.
- Asserting `RSTn` mid-frame aborts the frame immediately: outputs return to reset values and the partial byte is discarded. After release, the receiver waits for a fresh falling edge.
- Pin-to-detection latency is 3 `CLK` edges (2 sync flops plus the edge compare).
- Sample points, counted in `CLK` edges from the edge that enters START:
  - start-bit sample: HALF
  - data bit k: HALF + (k+1)·BAUD_DIV
  - stop-bit sample: HALF + 9·BAUD_DIV
- `rx_done`/`frame_err` are registered at the stop-sample edge. They are high during the following cycle only.
- Tolerated baud mismatch is about ±4% (sampling stays within the bit over 9.5 bits).

## Test plan
All scenarios use `BAUD_DIV`=16, a 10 ns clock, bit time 160 ns, and the line idle high.
- Reset: hold `RSTn`=0 for 100 ns with the line high. Required: `rx_data`=0x00, `rx_done`=0, `frame_err`=0, `rx_busy`=0. Release; the outputs stay the same with no activity.
- Single frame 0x55: drive start, 1,0,1,0,1,0,1,0, stop. Required:
  - exactly one `rx_done` pulse, with `rx_data`=0x55 in that cycle
  - `frame_err` never high
  - `rx_busy` low after the stop sample
- Back-to-back 0xA3 then 0x0F, with the second start bit immediately after a 1-bit stop. Required: two `rx_done` pulses carrying 0xA3 then 0x0F, with no `frame_err`.
- Glitch: drive the line low for 5 cycles (< HALF=8), then high. Required: `rx_busy` rises, then drops after the start sample; no `rx_done` or `frame_err`; `rx_data` unchanged.
- Framing error and break:
  - Frame 0xFF with the stop bit driven 0, then the line held low for 20 bit times. Required: one `frame_err` pulse, no `rx_done`, and `rx_data` still 0x0F; no further activity while the line is low.
  - Then release high for 2 bits and send 0x81. Required: `rx_done` with 0x81.
- Reset mid-frame: assert `RSTn` during data bit 4 of frame 0x3C. Required: outputs go to reset values immediately and no `rx_done`. After release, a complete 0x3C frame yields `rx_done` with `rx_data`=0x3C.

Source files
------------

// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop synchronizer, falling-edge start detection,
// mid-bit sampling and one-cycle done / framing-error strobes.
module uart_rx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_done_q, rx_done_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_busy_q, rx_busy_d;
  logic            rx_s;
  logic            fall;

  assign rx_s = sync2_q;
  assign fall = prev_q & ~rx_s;

  // Synchronizer and edge-detect history idle high so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rs232_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    rx_busy_d   = rx_busy_q;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = START;
          cnt_d     = '0;
          rx_busy_d = 1'b1;
        end
      end

      // A start bit that is high again at its midpoint was only a glitch.
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d   = IDLE;
            rx_busy_d = 1'b0;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Leaving at mid-stop-bit gives half a bit of slack for a following start edge.
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          rx_busy_d = 1'b0;
          if (rx_s) begin
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        rx_busy_d = 1'b0;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed scenarios plus randomized frames checked
// against a frame-level model of when and what the receiver must report.
module tb_uart_rx;

  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;
  // Pin edge to stop-sample edge: 3 detection edges, half a bit, then 9 full bits.
  localparam int LAT  = 3 + HALF + 9 * BAUD;

  logic       CLK;
  logic       RSTn;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int overlap = 0;

  int         ev_kind[$];
  logic [7:0] ev_data[$];
  int         ev_cyc[$];
  logic       ev_busy[$];

  uart_rx #(.BAUD_DIV(BAUD)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .rs232_rx (rs232_rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Event recorder: every strobe cycle is logged with the cycle it is seen in.
  always @(negedge CLK) begin
    if (rx_done === 1'b1 || frame_err === 1'b1) begin
      ev_kind.push_back(rx_done === 1'b1 ? 1 : 2);
      ev_data.push_back(rx_data);
      ev_cyc.push_back(cyc);
      ev_busy.push_back(rx_busy);
    end
    if (rx_done === 1'b1 && frame_err === 1'b1) overlap++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_events();
    ev_kind.delete();
    ev_data.delete();
    ev_cyc.delete();
    ev_busy.delete();
  endtask

  task automatic idle(input int n);
    rs232_rx = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Called at a negedge; returns at a negedge with the stop level still driven.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rs232_rx = bits[i];
      repeat (BAUD) @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    rs232_rx = 1'b1;
    #100;
    @(negedge CLK);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got=%h required=00", rx_data); end
    total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_rx_done: got=%b required=0", rx_done); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got=%b required=0", frame_err); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_rx_busy: got=%b required=0", rx_busy); end
    RSTn = 1'b1;
    clear_events();
    repeat (20) @(negedge CLK);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL post_reset_rx_data: got=%h required=00", rx_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL post_reset_rx_busy: got=%b required=0", rx_busy); end
    total++; if (ev_kind.size() !== 0) begin bad++; $display("FAIL post_reset_events: got=%0d required=0", ev_kind.size()); end
  endtask

  task automatic test_single_frame();
    int s;
    clear_events();
    send_frame(8'h55, 1'b1, s);
    idle(4);
    total++; if (ev_kind.size() !== 1) begin bad++; $display("FAIL single_count: got=%0d required=1", ev_kind.size()); end
    if (ev_kind.size() >= 1) begin
      total++; if (ev_kind[0] !== 1) begin bad++; $display("FAIL single_kind: got=%0d required=1(done)", ev_kind[0]); end
      total++; if (ev_data[0] !== 8'h55) begin bad++; $display("FAIL single_data: got=%h required=55", ev_data[0]); end
      total++; if (ev_cyc[0] !== s + LAT) begin bad++; $display("FAIL single_latency: got=%0d required=%0d", ev_cyc[0] - s, LAT); end
      total++; if (ev_busy[0] !== 1'b0) begin bad++; $display("FAIL single_busy_after_stop: got=%b required=0", ev_busy[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int s[2];
    logic [7:0] want[2];
    want[0] = 8'hA3;
    want[1] = 8'h0F;
    clear_events();
    send_frame(want[0], 1'b1, s[0]);
    send_frame(want[1], 1'b1, s[1]);
    idle(4);
    total++; if (ev_kind.size() !== 2) begin bad++; $display("FAIL b2b_count: got=%0d required=2", ev_kind.size()); end
    for (int i = 0; i < 2 && i < ev_kind.size(); i++) begin
      total++; if (ev_kind[i] !== 1) begin bad++; $display("FAIL b2b_kind[%0d]: got=%0d required=1(done)", i, ev_kind[i]); end
      total++; if (ev_data[i] !== want[i]) begin bad++; $display("FAIL b2b_data[%0d]: got=%h required=%h", i, ev_data[i], want[i]); end
      total++; if (ev_cyc[i] !== s[i] + LAT) begin bad++; $display("FAIL b2b_latency[%0d]: got=%0d required=%0d", i, ev_cyc[i] - s[i], LAT); end
    end
  endtask

  task automatic test_glitch();
    int s;
    int busy_cnt;
    int first_busy;
    busy_cnt   = 0;
    first_busy = -1;
    clear_events();
    s = cyc;
    rs232_rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (rx_busy === 1'b1) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc - s;
      end
      if (cyc - s == 5) rs232_rx = 1'b1;
    end
    total++; if (first_busy !== 3) begin bad++; $display("FAIL glitch_busy_rise: got=%0d required=3", first_busy); end
    total++; if (busy_cnt !== HALF) begin bad++; $display("FAIL glitch_busy_len: got=%0d required=%0d", busy_cnt, HALF); end
    total++; if (ev_kind.size() !== 0) begin bad++; $display("FAIL glitch_events: got=%0d required=0", ev_kind.size()); end
    total++; if (rx_data !== 8'h0F) begin bad++; $display("FAIL glitch_rx_data: got=%h required=0f", rx_data); end
  endtask

  task automatic test_break();
    int s;
    int busy_cnt;
    busy_cnt = 0;
    clear_events();
    send_frame(8'hFF, 1'b0, s);
    for (int i = 0; i < 20 * BAUD; i++) begin
      @(negedge CLK);
      if (rx_busy === 1'b1) busy_cnt++;
    end
    total++; if (ev_kind.size() !== 1) begin bad++; $display("FAIL break_count: got=%0d required=1", ev_kind.size()); end
    if (ev_kind.size() >= 1) begin
      total++; if (ev_kind[0] !== 2) begin bad++; $display("FAIL break_kind: got=%0d required=2(frame_err)", ev_kind[0]); end
      total++; if (ev_data[0] !== 8'h0F) begin bad++; $display("FAIL break_rx_data: got=%h required=0f", ev_data[0]); end
      total++; if (ev_cyc[0] !== s + LAT) begin bad++; $display("FAIL break_latency: got=%0d required=%0d", ev_cyc[0] - s, LAT); end
    end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL break_busy_while_low: got=%0d required=0", busy_cnt); end
    idle(2 * BAUD);
    clear_events();
    send_frame(8'h81, 1'b1, s);
    idle(4);
    total++; if (ev_kind.size() !== 1) begin bad++; $display("FAIL recover_count: got=%0d required=1", ev_kind.size()); end
    if (ev_kind.size() >= 1) begin
      total++; if (ev_kind[0] !== 1) begin bad++; $display("FAIL recover_kind: got=%0d required=1(done)", ev_kind[0]); end
      total++; if (ev_data[0] !== 8'h81) begin bad++; $display("FAIL recover_data: got=%h required=81", ev_data[0]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int s;
    b = 8'h3C;
    clear_events();
    rs232_rx = 1'b0;
    repeat (BAUD) @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      rs232_rx = b[k];
      repeat (BAUD) @(negedge CLK);
    end
    rs232_rx = b[4];
    repeat (HALF) @(negedge CLK);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got=%b required=1", rx_busy); end
    #2 RSTn = 1'b0;
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_rx_data: got=%h required=00", rx_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL midrst_rx_busy: got=%b required=0", rx_busy); end
    total++; if (rx_done !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL midrst_strobes: got=%b%b required=00", rx_done, frame_err); end
    rs232_rx = 1'b1;
    repeat (4) @(negedge CLK);
    RSTn = 1'b1;
    idle(2 * BAUD);
    total++; if (ev_kind.size() !== 0) begin bad++; $display("FAIL midrst_events: got=%0d required=0", ev_kind.size()); end
    clear_events();
    send_frame(b, 1'b1, s);
    idle(4);
    total++; if (ev_kind.size() !== 1) begin bad++; $display("FAIL midrst_resend_count: got=%0d required=1", ev_kind.size()); end
    if (ev_kind.size() >= 1) begin
      total++; if (ev_data[0] !== 8'h3C || ev_kind[0] !== 1) begin bad++; $display("FAIL midrst_resend: got=kind%0d/%h required=kind1/3c", ev_kind[0], ev_data[0]); end
    end
  endtask

  // Model: each frame yields exactly one strobe LAT cycles after its start edge;
  // a good stop bit reports the byte, a bad one reports the previous good byte.
  task automatic test_random();
    int         exp_kind[$];
    logic [7:0] exp_data[$];
    int         exp_cyc[$];
    logic [7:0] last_good;
    logic [7:0] b;
    logic       stop_bit;
    int         s;
    int         gap;
    last_good = 8'h3C;
    clear_events();
    for (int n = 0; n < 12; n++) begin
      b        = 8'($urandom);
      stop_bit = ($urandom_range(0, 3) != 0);
      gap      = stop_bit ? $urandom_range(0, 40) : $urandom_range(2, 40);
      send_frame(b, stop_bit, s);
      if (stop_bit) last_good = b;
      exp_kind.push_back(stop_bit ? 1 : 2);
      exp_data.push_back(last_good);
      exp_cyc.push_back(s + LAT);
      if (gap > 0) idle(gap);
    end
    idle(8);
    total++; if (ev_kind.size() !== exp_kind.size()) begin bad++; $display("FAIL rand_count: got=%0d required=%0d", ev_kind.size(), exp_kind.size()); end
    for (int i = 0; i < exp_kind.size() && i < ev_kind.size(); i++) begin
      total++;
      if (ev_kind[i] !== exp_kind[i] || ev_data[i] !== exp_data[i] || ev_cyc[i] !== exp_cyc[i]) begin
        bad++;
        $display("FAIL rand_frame[%0d]: got=kind%0d/%h@%0d required=kind%0d/%h@%0d",
                 i, ev_kind[i], ev_data[i], ev_cyc[i], exp_kind[i], exp_data[i], exp_cyc[i]);
      end
    end
  endtask

  initial begin
    rs232_rx = 1'b1;
    RSTn     = 1'b1;
    #1 RSTn  = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_random();
    total++; if (overlap !== 0) begin bad++; $display("FAIL strobe_overlap: got=%0d required=0", overlap); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
